// File: rtl/mcp3008_scan_ctrl_if.sv
// rtl/mcp3008_scan_ctrl_if.sv - SPI link between the scan controller and the MCP3008
interface mcp3008_scan_ctrl_if;
    logic sclk;
    logic csn;
    logic mosi;
    logic miso;

    modport master (output sclk, output csn, output mosi, input miso);
    modport slave  (input sclk, input csn, input mosi, output miso);
endinterface

// File: rtl/mcp3008_scan_ctrl.sv
// rtl/mcp3008_scan_ctrl.sv - MCP3008 SPI scan controller with per-channel result bank
// Optional null-bit checking: define MCP3008_NULLBIT_CHECK_EN.
module mcp3008_scan_ctrl #(
    parameter int CLK_DIV = 8,
    parameter int CS_GAP  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 start,
    input  logic [7:0]           ch_mask,
    mcp3008_scan_ctrl_if.master  spi,
    output logic [7:0][9:0]      data,
    output logic                 res_valid,
    output logic [2:0]           res_ch,
    output logic                 scan_done,
    output logic                 busy,
    output logic                 err
);
    localparam int CW = 16;

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_GAP} state_t;
    state_t state, state_nx;

    logic [CW-1:0] cnt;
    logic          hi;
    logic [4:0]    edge_k;
    logic [9:0]    shreg;
    logic [7:0]    rem;
    logic [2:0]    cur;
    logic [7:0]    rem_after;
    logic          phase_end, gap_end, start_scan, restart;

    function automatic logic [2:0] lowest(input logic [7:0] m);
        lowest = 3'd0;
        for (int i = 7; i >= 0; i--)
            if (m[i]) lowest = 3'(i);
    endfunction

    assign phase_end  = (cnt == CW'(CLK_DIV - 1));
    assign gap_end    = (cnt == CW'(CS_GAP - 1));
    assign rem_after  = rem & ~(8'd1 << cur);
    assign start_scan = (enable | start) && (ch_mask != 8'd0);
    assign restart    = enable && (ch_mask != 8'd0);
    assign res_ch     = cur;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start_scan) state_nx = S_SETUP;
            S_SETUP: if (phase_end) state_nx = S_SHIFT;
            S_SHIFT: if (phase_end && hi && edge_k == 5'd17) state_nx = S_HOLD;
            S_HOLD:  if (phase_end) state_nx = S_GAP;
            S_GAP:   if (gap_end) state_nx = (rem_after != 8'd0 || restart) ? S_SETUP : S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // The command bit for edge k is held across the whole sclk period; the ADC samples on the rise.
    always_comb begin
        spi.csn  = 1'b1;
        spi.sclk = 1'b0;
        spi.mosi = 1'b0;
        busy     = (state != S_IDLE);
        case (state)
            S_SETUP: begin
                spi.csn  = 1'b0;
                spi.mosi = 1'b1;
            end
            S_SHIFT: begin
                spi.csn  = 1'b0;
                spi.sclk = hi;
                case (edge_k)
                    5'd1, 5'd2: spi.mosi = 1'b1;
                    5'd3:       spi.mosi = cur[2];
                    5'd4:       spi.mosi = cur[1];
                    5'd5:       spi.mosi = cur[0];
                    default:    spi.mosi = 1'b0;
                endcase
            end
            S_HOLD:  spi.csn = 1'b0;
            default: ;
        endcase
    end

`ifdef MCP3008_NULLBIT_CHECK_EN
    logic null_bad, err_q;
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            hi        <= 1'b0;
            edge_k    <= 5'd0;
            shreg     <= 10'd0;
            rem       <= 8'd0;
            cur       <= 3'd0;
            data      <= '0;
            res_valid <= 1'b0;
            scan_done <= 1'b0;
`ifdef MCP3008_NULLBIT_CHECK_EN
            null_bad  <= 1'b0;
            err_q     <= 1'b0;
`endif
        end else begin
            res_valid <= 1'b0;
            scan_done <= 1'b0;
            if (state_nx != state || (state == S_SHIFT && phase_end))
                cnt <= '0;
            else if (state != S_IDLE)
                cnt <= cnt + 1'b1;

            case (state)
                S_IDLE: if (start_scan) begin
                    rem <= ch_mask;
                    cur <= lowest(ch_mask);
                end
                S_SETUP: begin
                    hi     <= 1'b0;
                    edge_k <= 5'd1;
`ifdef MCP3008_NULLBIT_CHECK_EN
                    null_bad <= 1'b0;
`endif
                end
                S_SHIFT: begin
                    // miso is taken in the first clk of each sclk high phase.
                    if (hi && cnt == '0) begin
`ifdef MCP3008_NULLBIT_CHECK_EN
                        if (edge_k == 5'd7) null_bad <= (spi.miso !== 1'b0);
`endif
                        if (edge_k >= 5'd8) shreg <= {shreg[8:0], spi.miso};
                    end
                    if (phase_end) begin
                        hi <= ~hi;
                        if (hi) edge_k <= edge_k + 5'd1;
                    end
                end
                S_HOLD: if (phase_end) begin
`ifdef MCP3008_NULLBIT_CHECK_EN
                    if (null_bad) begin
                        err_q <= 1'b1;
                    end else begin
                        data[cur] <= shreg;
                        res_valid <= 1'b1;
                    end
`else
                    data[cur] <= shreg;
                    res_valid <= 1'b1;
`endif
                end
                S_GAP: if (gap_end) begin
                    if (rem_after != 8'd0) begin
                        rem <= rem_after;
                        cur <= lowest(rem_after);
                    end else begin
                        scan_done <= 1'b1;
                        if (restart) begin
                            rem <= ch_mask;
                            cur <= lowest(ch_mask);
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/mcp3008_scan_ctrl.md
Name: mcp3008_scan_ctrl

Overview:
- SPI master and channel scheduler for the MCP3008 8-channel 10-bit ADC.
- Generates sclk/csn/mosi and issues single-ended conversions over a programmable channel mask in ascending order.
- Captures the 10-bit results into a per-channel result bank read by the motion/sensor logic.
- Supports continuous scanning and one-shot scans.

Parameters:
- CLK_DIV, 8: clk cycles per sclk half-period (>=1).
- CS_GAP, 16: minimum clk cycles csn is held high between frames (>=1).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  continuous scan while high
- start  in  1  one-cycle pulse: one scan when enable low
- ch_mask  in  8  bit i=1 selects channel i; sampled at scan start
- sclk  out  1  SPI clock, idle low (mode 0,0)
- csn  out  1  ADC chip select, active low
- mosi  out  1  command data
- miso  in  1  ADC data
- data  out  8x10 (packed [7:0][9:0])  latest result per channel
- res_valid  out  1  one-cycle pulse: a result was written
- res_ch  out  3  channel of the current/last frame
- scan_done  out  1  one-cycle pulse after last selected channel of a scan
- busy  out  1  high from scan start to end of final CS gap
- err  out  1  sticky null-bit error (see Optional Feature)

Behaviour:
- Reset (async, rst_n=0):
  - csn=1, sclk=0, mosi=0.
  - data=0, res_valid=0, res_ch=0, scan_done=0, busy=0, err=0.
  - FSM goes to IDLE.
  - Mid-frame reset aborts the frame immediately; no result is written.
- States:
  - IDLE:
    - Scan starts when (enable | start) and ch_mask!=0: latch mask, select lowest set bit, busy=1, goto SETUP.
    - ch_mask==0: stay IDLE, start ignored, busy=0.
  - SETUP: csn=0, sclk=0, mosi=1 (start bit); wait CLK_DIV cycles; goto SHIFT.
  - SHIFT: 17 sclk periods, each CLK_DIV low then CLK_DIV high.
    - Rising-edge index k=1..17.
    - mosi presented during the low phase before edge k: k=1 start=1, k=2 single=1, k=3..5 ch[2:0] MSB first, k>=6 mosi=0.
    - miso is sampled in the clk cycle sclk goes high: k=7 is the null bit, k=8..17 are D9..D0 shifted MSB first.
  - HOLD: after edge 17, sclk low for CLK_DIV cycles.
    - Then csn=1.
    - data[res_ch] <= shifted value; res_valid pulses in the same cycle csn rises.
    - Goto GAP.
  - GAP: csn high for CS_GAP cycles, then:
    - More selected channels remain: next higher channel, goto SETUP.
    - Else: scan_done pulses for 1 cycle.
      - enable=1: relatch ch_mask and restart (mask 0 goes to IDLE).
      - enable=0: busy=0, goto IDLE.
- Frame length: exactly 17 rising edges; total = CLK_DIV*(1+34+1) + CS_GAP clk cycles per channel.
- enable dropped mid-scan: the current scan completes, then IDLE; start is ignored while busy.
- ch_mask changes mid-scan have no effect until the next scan start.
- data bank entries of unselected channels hold their previous value.
- res_ch is valid from SETUP through the res_valid pulse.

Optional Feature:
- Macro: MCP3008_NULLBIT_CHECK_EN.
- Defined:
  - miso at edge k=7 must be 0.
  - If it is 1 (or X/Z in simulation, treated as 1), the frame's result is discarded: no data write, no res_valid.
  - err is set and stays set until reset. Scanning continues.
- Undefined: the null bit is ignored, err is tied 0, and every frame writes data.

Test Plan:
- Reset: CLK_DIV=2, CS_GAP=4, rst_n=0 -> csn=1, sclk=0, data=0, busy=0; release with ch_mask=0, enable=1 -> stays IDLE, busy=0.
- One-shot: ADC model data[3]=10'h2A5, ch_mask=8'h08, start pulse -> exactly 17 sclk rising edges; mosi 1,1,0,1,1 on edges 1-5; data[3]=10'h2A5; one res_valid with res_ch=3; scan_done 1 cycle; busy low after CS gap.
- Continuous: ch_mask=8'hA5, model channel i = 10'h100+i, enable=1 -> frames in order ch 0,2,5,7, repeated; data values match; scan_done once per pass; period = 4*(2*36+4) cycles.
- Mid-scan control: mask 8'hFF; after 2 frames set ch_mask=8'h01 and enable=0 -> remaining channels 2-7 complete, then IDLE; no frame for new mask.
- Reset mid-frame: assert rst_n at edge 10 of a frame -> csn=1 and sclk=0 asynchronously; prior data unchanged from before that frame's reset value (all 0); no res_valid.
- MCP3008_NULLBIT_CHECK_EN: force model miso=1 at null bit on ch 1 -> err=1, data[1] unchanged, no res_valid; other channels still updated.
